// File: rtl/bcd_counter_scan.sv
// bcd_counter_scan: four-digit BCD up/down counter with time-multiplexed digit scanner
module bcd_counter_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] count_value,
  output logic        carry_out,
  output logic        load_err,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_sel
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [15:0] inc, dec, lv;
  logic wrap_up, wrap_dn, bad, last;
  logic [DW-1:0] div;
  logic [1:0] idx;
  always_comb begin
    inc = count_value;
    dec = count_value;
    lv = load_value;
    wrap_up = 1'b1;
    wrap_dn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inc[4*i+:4] = wrap_up ? (count_value[4*i+:4] == 4'd9 ? 4'd0 : count_value[4*i+:4] + 4'd1) : count_value[4*i+:4];
      dec[4*i+:4] = wrap_dn ? (count_value[4*i+:4] == 4'd0 ? 4'd9 : count_value[4*i+:4] - 4'd1) : count_value[4*i+:4];
      wrap_up = wrap_up && count_value[4*i+:4] == 4'd9;
      wrap_dn = wrap_dn && count_value[4*i+:4] == 4'd0;
      bad = bad || load_value[4*i+:4] > 4'd9;
      lv[4*i+:4] = load_value[4*i+:4] > 4'd9 ? 4'd0 : load_value[4*i+:4];
    end
  end
  assign last = div == DW'(SCAN_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      count_value <= '0;
      carry_out <= 1'b0;
      load_err <= 1'b0;
      div <= '0;
      idx <= '0;
      bcd_out <= '0;
      digit_sel <= 4'b1110;
    end else begin
      count_value <= load ? lv : en ? (up_down ? inc : dec) : count_value;
      carry_out <= !load && en && (up_down ? wrap_up : wrap_dn);
      load_err <= load && bad;
      div <= last ? '0 : div + 1'b1;
      idx <= last ? idx + 2'd1 : idx;
      bcd_out <= count_value[4*idx+:4];
      digit_sel <= ~(4'b0001 << idx);
    end
  end
endmodule

// File: tb/tb_bcd_counter_scan.sv
// tb_bcd_counter_scan: directed self-checking bench for bcd_counter_scan
module tb_bcd_counter_scan;
  logic clk = 1'b0;
  logic reset, en, up_down, load;
  logic [15:0] load_value, count_value;
  logic carry_out, load_err;
  logic [3:0] bcd_out, digit_sel;
  int tests = 0;
  int fails = 0;
  logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] bcd_tab [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
  bcd_counter_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .count_value(count_value), .carry_out(carry_out),
    .load_err(load_err), .bcd_out(bcd_out), .digit_sel(digit_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1; en = 1'b0; up_down = 1'b0; load = 1'b0; load_value = '0;
    tick();
    chk("rst_count", count_value, 16'h0000);
    chk("rst_sel", 16'(digit_sel), 16'hE);
    chk("rst_bcd", 16'(bcd_out), 16'h0);
    chk("rst_carry", 16'(carry_out), 16'h0);
    chk("rst_err", 16'(load_err), 16'h0);
    reset = 1'b0;
    load = 1'b1; load_value = 16'h9998;
    tick();
    load = 1'b0;
    chk("ld9998", count_value, 16'h9998);
    chk("ld9998_err", 16'(load_err), 16'h0);
    chk("ld9998_carry", 16'(carry_out), 16'h0);
    en = 1'b1; up_down = 1'b1;
    tick();
    chk("up_9999", count_value, 16'h9999);
    chk("up_9999_carry", 16'(carry_out), 16'h0);
    tick();
    chk("up_wrap", count_value, 16'h0000);
    chk("up_wrap_carry", 16'(carry_out), 16'h1);
    en = 1'b0;
    tick();
    chk("hold_0000", count_value, 16'h0000);
    chk("carry_clear", 16'(carry_out), 16'h0);
    load = 1'b1; load_value = 16'h0001;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b0;
    tick();
    chk("dn_0000", count_value, 16'h0000);
    chk("dn_0000_carry", 16'(carry_out), 16'h0);
    tick();
    chk("dn_wrap", count_value, 16'h9999);
    chk("dn_wrap_carry", 16'(carry_out), 16'h1);
    en = 1'b0;
    tick();
    chk("dn_carry_clear", 16'(carry_out), 16'h0);
    load = 1'b1; load_value = 16'h0109;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b0;
    tick();
    en = 1'b0;
    chk("dn_0108", count_value, 16'h0108);
    chk("dn_0108_carry", 16'(carry_out), 16'h0);
    load = 1'b1; load_value = 16'h0199;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b1;
    tick();
    en = 1'b0;
    chk("up_0200", count_value, 16'h0200);
    chk("up_0200_carry", 16'(carry_out), 16'h0);
    load = 1'b1; load_value = 16'h1A3F;
    tick();
    load = 1'b0;
    chk("ld_bad_count", count_value, 16'h1030);
    chk("ld_bad_err", 16'(load_err), 16'h1);
    tick();
    chk("ld_bad_err_clear", 16'(load_err), 16'h0);
    chk("ld_bad_hold", count_value, 16'h1030);
    load = 1'b1; en = 1'b1; up_down = 1'b1; load_value = 16'h0500;
    tick();
    load = 1'b0; en = 1'b0;
    chk("ld_en_count", count_value, 16'h0500);
    chk("ld_en_carry", 16'(carry_out), 16'h0);
    chk("ld_en_err", 16'(load_err), 16'h0);
    // align the scanner: reset edge is n=0, load 1234 lands on edge 1
    reset = 1'b1;
    tick();
    reset = 1'b0; load = 1'b1; load_value = 16'h1234;
    tick();
    load = 1'b0;
    chk("scan_count", count_value, 16'h1234);
    for (int n = 2; n <= 17; n++) begin
      tick();
      chk($sformatf("scan_sel_%0d", n), 16'(digit_sel), 16'(sel_tab[((n - 1) / 4) % 4]));
      chk($sformatf("scan_bcd_%0d", n), 16'(bcd_out), 16'(bcd_tab[((n - 1) / 4) % 4]));
    end
    en = 1'b1; up_down = 1'b1;
    for (int n = 18; n <= 25; n++) tick();
    chk("mid_sel", 16'(digit_sel), 16'hB);
    chk("mid_count", count_value, 16'h1242);
    reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0;
    chk("mid_rst_count", count_value, 16'h0000);
    chk("mid_rst_sel", 16'(digit_sel), 16'hE);
    chk("mid_rst_bcd", 16'(bcd_out), 16'h0);
    chk("mid_rst_carry", 16'(carry_out), 16'h0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk($sformatf("dwell_sel_%0d", n), 16'(digit_sel), 16'hE);
    end
    tick();
    chk("dwell_next_sel", 16'(digit_sel), 16'hD);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_counter_scan.md
Name: bcd_counter_scan

Overview:
- Four-digit BCD up/down counter with a time-multiplexed digit scanner.
- Sits directly upstream of the BCD-to-7-segment decoder. Its `bcd_out` drives the decoder's 4-bit `bcd` input one digit at a time; `digit_sel` drives the common anodes of a 4-digit display.
- The count source is an external one-cycle strobe (`en`), e.g. a prescaled tick.

Parameters:
- SCAN_DIV, 4, clock cycles each digit stays selected; legal range ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count strobe; one step per cycle while high.
- up_down  input  1  1 = count up, 0 = count down; sampled only with `en`.
- load  input  1  synchronous parallel load of `load_value`.
- load_value  input  16  four packed BCD digits, [3:0] = ones … [15:12] = thousands.
- count_value  output  16  current count as packed BCD, same packing as `load_value`.
- carry_out  output  1  one-cycle pulse on wrap 9999→0000 (up) or 0000→9999 (down).
- load_err  output  1  one-cycle pulse when a loaded digit was >9.
- bcd_out  output  4  BCD digit currently displayed; feeds decoder `bcd`.
- digit_sel  output  4  active-low one-hot anode select, bit0 = ones digit.

Behaviour:
- Clocking and reset: one clock domain, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - `count_value` = 16'h0000.
  - Scan index = 0; scan divider = 0.
  - `bcd_out` = 4'h0.
  - `digit_sel` = 4'b1110.
  - `carry_out` = 0; `load_err` = 0.
- Priority of count-register updates: `reset` > `load` > `en`. When `load` and `en` are asserted together, the load wins and no count step occurs that cycle.
- Load:
  - `count_value` <= `load_value` next edge, digit-wise.
  - Any digit >9 is replaced by 0.
  - `load_err` = 1 for exactly the cycle after the load if any digit was replaced.
  - Load never produces `carry_out`.
- Count up (`en`=1, `up_down`=1):
  - Ones digit increments.
  - A digit at 9 rolls to 0 and carries into the next digit (ripple within the same cycle).
  - 9999 → 0000, with `carry_out`=1 on the cycle following that edge.
- Count down (`en`=1, `up_down`=0):
  - A digit at 0 rolls to 9 and borrows from the next digit.
  - 0000 → 9999, with `carry_out`=1.
- `en`=0: count holds. `carry_out` and `load_err` are 0 whenever their event did not occur on the preceding edge.
- Scanner (free-running, independent of `en` and `load`):
  - The divider counts 0..SCAN_DIV-1.
  - When the divider is at SCAN_DIV-1, it returns to 0 and the scan index advances 0→1→2→3→0.
  - SCAN_DIV=1 advances the index every cycle.
- Display registers, updated every cycle:
  - `bcd_out` <= digit[index] of the pre-edge `count_value`.
  - `digit_sel` <= ~(4'b0001 << index).
  - Both are registered from the same index, so they are always mutually consistent.
  - They lag the index by one cycle and a count change by one cycle.
- Exactly one `digit_sel` bit is low at all times after reset; an all-ones or multi-low pattern is an error.
- Reset mid-scan or mid-count: all state returns to reset values on that edge. The scan restarts at the ones digit with a full SCAN_DIV dwell.

Test Plan:
- Reset → `count_value`=0000, `digit_sel`=1110, `bcd_out`=0, `carry_out`=0, `load_err`=0 at the first edge with `reset`=1.
- Load 16'h9998, then `en`=1 and `up_down`=1 for 2 cycles → `count_value` 9999 then 0000; `carry_out`=1 only on the cycle after the wrap edge.
- Load 16'h0001, then `en`=1 and `up_down`=0 for 2 cycles → 0000 then 9999 with one `carry_out` pulse. Load 16'h0109 followed by one down step → 0108; a following up step from 0199 → 0200, with no carry.
- Load 16'h1A3F → `count_value`=16'h1030 and a one-cycle `load_err`. Load with `en` high in the same cycle → no count step.
- SCAN_DIV=4, count held at 16'h1234 → repeating sequence:
  - `digit_sel` 1110 / `bcd_out` 4 for 4 cycles,
  - then 1101 / 3,
  - then 1011 / 2,
  - then 0111 / 1.
  - Feeding the decoder yields the segment patterns for 4, 3, 2, 1.
- Assert `reset` while `digit_sel`=1011 and the count is mid-run → next edge gives 0000 and `digit_sel`=1110; the ones digit dwells for a full 4 cycles after reset is released.
